// File: rtl/knn_vote_pkg.sv
// knn_vote_pkg
//   Shared definitions for the KNN voting block: FSM state encodings and a
//   width helper used to size index registers.
//   No ports (package).
package knn_vote_pkg;

  // FSM state encodings kept as plain constants so older blocks on the
  // sorter side can share the same numeric values.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_SCAN  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Bits needed to hold an index in 0..value-1, never less than one bit.
  function automatic int clog2Min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/knn_class_counter.sv
// knn_class_counter
//   Bank of NCLASS {vote count, first index} pairs used while tallying the
//   K nearest neighbours. "first" holds the neighbour index at which the
//   class received its first vote, which the voter uses for tie-breaking.
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset (clears the bank)
//   clear_i      in   clear every count and first index
//   inc_i        in   add one vote to class inc_class_i
//   inc_class_i  in   class receiving the vote
//   inc_idx_i    in   neighbour index of this vote
//   rd_class_i   in   class to read back
//   rd_cnt_o     out  vote count of rd_class_i
//   rd_first_o   out  first-vote index of rd_class_i
module knn_class_counter
  import knn_vote_pkg::*;
#(
  parameter int TYPE_W = 3,
  parameter int CW     = 3,
  parameter int FW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              inc_i,
  input  logic [TYPE_W-1:0] inc_class_i,
  input  logic [FW-1:0]     inc_idx_i,
  input  logic [TYPE_W-1:0] rd_class_i,
  output logic [CW-1:0]     rd_cnt_o,
  output logic [FW-1:0]     rd_first_o
);

  localparam int NCLASS = 1 << TYPE_W;

  logic [CW-1:0] cnt_q   [NCLASS];
  logic [FW-1:0] first_q [NCLASS];

  // Counts can never exceed K, so CW bits never wrap. The first index is
  // written only on the 0 -> 1 transition of a class count.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      for (int i = 0; i < NCLASS; i++) begin
        cnt_q[i]   <= '0;
        first_q[i] <= '0;
      end
    end else if (inc_i) begin
      cnt_q[inc_class_i] <= cnt_q[inc_class_i] + 1'b1;
      if (cnt_q[inc_class_i] == '0) begin
        first_q[inc_class_i] <= inc_idx_i;
      end
    end
  end

  assign rd_cnt_o   = cnt_q[rd_class_i];
  assign rd_first_o = first_q[rd_class_i];

endmodule

// File: rtl/knn_vote.sv
// knn_vote
//   Takes one ascending-distance vector of 2^L {distance, class} pairs from
//   the sorter, tallies the classes of the K nearest entries one per cycle,
//   scans all classes for the majority (ties go to the class owning the
//   nearest neighbour) and reports the winner, its votes and the nearest
//   distance.
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   in_valid     in   sorted vector present
//   in           in   W*2^L distances, slice 0 = nearest
//   in_type      in   TYPE_W*2^L class labels, same slice order
//   in_ready     out  vector can be accepted this cycle
//   out_valid    out  one-cycle pulse, result fields valid
//   out_class    out  winning class
//   out_votes    out  votes of the winning class
//   out_nearest  out  slice-0 distance of the voted vector
//   drop_err     out  sticky: a vector arrived while busy
module knn_vote
  import knn_vote_pkg::*;
#(
  parameter int L      = 4,
  parameter int W      = 16,
  parameter int TYPE_W = 3,
  parameter int K      = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [W*(1<<L)-1:0]        in,
  input  logic [TYPE_W*(1<<L)-1:0]   in_type,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [TYPE_W-1:0]          out_class,
  output logic [$clog2(K+1)-1:0]     out_votes,
  output logic [W-1:0]               out_nearest,
  output logic                       drop_err
);

  localparam int NENT   = 1 << L;
  localparam int NCLASS = 1 << TYPE_W;
  localparam int CW     = $clog2(K + 1);
  localparam int FW     = clog2Min1(K);

  generate
    if (K < 1 || K > NENT) begin : gBadK
      $error("knn_vote: K must lie in 1..2^L");
    end
  endgenerate

  // Only the K nearest labels and the slice-0 distance are ever consumed.
  generate
    if (K < NENT) begin : gUnusedTypes
      logic unusedTypes;
      assign unusedTypes = ^in_type[NENT*TYPE_W-1:K*TYPE_W];
    end
    if (NENT > 1) begin : gUnusedDist
      logic unusedDist;
      assign unusedDist = ^in[NENT*W-1:W];
    end
  endgenerate

  logic [1:0]        state_q, state_d;
  logic [FW-1:0]     idx_q, idx_d;
  logic [TYPE_W-1:0] c_q, c_d;
  logic [TYPE_W-1:0] types_q [K];
  logic [TYPE_W-1:0] types_d [K];
  logic [W-1:0]      dist0_q, dist0_d;
  logic [CW-1:0]     bestCnt_q, bestCnt_d;
  logic [FW-1:0]     bestFirst_q, bestFirst_d;
  logic [TYPE_W-1:0] bestClass_q, bestClass_d;
  logic [TYPE_W-1:0] outClass_q, outClass_d;
  logic [CW-1:0]     outVotes_q, outVotes_d;
  logic [W-1:0]      outNearest_q, outNearest_d;
  logic              dropErr_q, dropErr_d;

  logic              accept;
  logic              cntClear;
  logic              cntInc;
  logic [CW-1:0]     rdCnt;
  logic [FW-1:0]     rdFirst;
  logic              replace;

  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign accept   = in_valid && in_ready;

  knn_class_counter #(
    .TYPE_W (TYPE_W),
    .CW     (CW),
    .FW     (FW)
  ) uCounter (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (cntClear),
    .inc_i       (cntInc),
    .inc_class_i (types_q[idx_q]),
    .inc_idx_i   (idx_q),
    .rd_class_i  (c_q),
    .rd_cnt_o    (rdCnt),
    .rd_first_o  (rdFirst)
  );

  // A class takes the lead on strictly more votes, or on equal votes when
  // its first vote came from a nearer neighbour. With bestCnt cleared to 0
  // the first voted class always takes the lead.
  assign replace = (rdCnt != '0) &&
                   ((rdCnt > bestCnt_q) ||
                    ((rdCnt == bestCnt_q) && (rdFirst < bestFirst_q)));

  // Next-state logic. Accepting is only possible in IDLE and DONE, so the
  // capture path is shared; a DONE-cycle accept starts the next vote while
  // the current result is still being presented.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    c_d          = c_q;
    types_d      = types_q;
    dist0_d      = dist0_q;
    bestCnt_d    = bestCnt_q;
    bestFirst_d  = bestFirst_q;
    bestClass_d  = bestClass_q;
    outClass_d   = outClass_q;
    outVotes_d   = outVotes_q;
    outNearest_d = outNearest_q;
    dropErr_d    = dropErr_q | (in_valid & ~in_ready);
    cntClear     = 1'b0;
    cntInc       = 1'b0;

    if (accept) begin
      for (int i = 0; i < K; i++) begin
        types_d[i] = in_type[i*TYPE_W +: TYPE_W];
      end
      dist0_d  = in[W-1:0];
      cntClear = 1'b1;
      idx_d    = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        cntInc = 1'b1;
        if (idx_q == FW'(K - 1)) begin
          state_d     = ST_SCAN;
          c_d         = '0;
          bestCnt_d   = '0;
          bestFirst_d = '0;
          bestClass_d = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_SCAN: begin
        if (replace) begin
          bestCnt_d   = rdCnt;
          bestFirst_d = rdFirst;
          bestClass_d = c_q;
        end
        if (c_q == TYPE_W'(NCLASS - 1)) begin
          state_d      = ST_DONE;
          outClass_d   = bestClass_d;
          outVotes_d   = bestCnt_d;
          outNearest_d = dist0_q;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      default: begin
        state_d = accept ? ST_COUNT : ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any vote in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      c_q          <= '0;
      for (int i = 0; i < K; i++) types_q[i] <= '0;
      dist0_q      <= '0;
      bestCnt_q    <= '0;
      bestFirst_q  <= '0;
      bestClass_q  <= '0;
      outClass_q   <= '0;
      outVotes_q   <= '0;
      outNearest_q <= '0;
      dropErr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      c_q          <= c_d;
      types_q      <= types_d;
      dist0_q      <= dist0_d;
      bestCnt_q    <= bestCnt_d;
      bestFirst_q  <= bestFirst_d;
      bestClass_q  <= bestClass_d;
      outClass_q   <= outClass_d;
      outVotes_q   <= outVotes_d;
      outNearest_q <= outNearest_d;
      dropErr_q    <= dropErr_d;
    end
  end

  assign out_valid   = (state_q == ST_DONE);
  assign out_class   = outClass_q;
  assign out_votes   = outVotes_q;
  assign out_nearest = outNearest_q;
  assign drop_err    = dropErr_q;

endmodule

// File: tb/tb_knn_vote.sv
// tb_knn_vote
//   Scoreboard bench for knn_vote: the stimulus side pushes the expected
//   result of each accepted vector, a negedge monitor pops and compares on
//   every out_valid pulse, including the cycle at which it arrives.
module tb_knn_vote;

  localparam int L      = 4;
  localparam int W      = 16;
  localparam int TYPE_W = 3;
  localparam int K      = 5;
  localparam int NENT   = 1 << L;
  localparam int NCLASS = 1 << TYPE_W;
  localparam int CW     = $clog2(K + 1);
  localparam int LAT    = K + NCLASS + 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic [NENT*W-1:0]        inData;
  logic [NENT*TYPE_W-1:0]   inType;
  logic                     in_ready;
  logic                     out_valid;
  logic [TYPE_W-1:0]        out_class;
  logic [CW-1:0]            out_votes;
  logic [W-1:0]             out_nearest;
  logic                     drop_err;

  knn_vote #(
    .L(L), .W(W), .TYPE_W(TYPE_W), .K(K)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in          (inData),
    .in_type     (inType),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_class   (out_class),
    .out_votes   (out_votes),
    .out_nearest (out_nearest),
    .drop_err    (drop_err)
  );

  always #5 clk = ~clk;

  // Free-running cycle count, used to time each result against its accept.
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     cls;
    int     votes;
    int     nearest;
    longint due;
  } expect_t;

  expect_t sbq[$];
  expect_t monE;

  int nCompared   = 0;
  int nMismatched = 0;
  bit lastAcceptInDone;

  logic [TYPE_W-1:0] curTypes [NENT];
  logic [W-1:0]      curDist  [NENT];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL %s: bound expired or event not expected", name);
  endtask

  // Reference vote: majority over the K nearest labels; among tied classes
  // the winner is the one that appears earliest in distance order.
  function automatic void refVote(output int cls, output int votes);
    int cnt [NCLASS];
    int best = 0;
    foreach (cnt[c]) cnt[c] = 0;
    for (int i = 0; i < K; i++) cnt[curTypes[i]]++;
    foreach (cnt[c]) if (cnt[c] > best) best = cnt[c];
    cls = 0;
    for (int i = K - 1; i >= 0; i--) if (cnt[curTypes[i]] == best) cls = curTypes[i];
    votes = best;
  endfunction

  task automatic loadTypes(input int t0, input int t1, input int t2, input int t3,
                           input int t4, input int fill);
    int t [5] = '{t0, t1, t2, t3, t4};
    for (int i = 0; i < NENT; i++) begin
      curTypes[i] = (i < 5) ? TYPE_W'(t[i]) : TYPE_W'(fill);
      curDist[i]  = W'($urandom);
    end
  endtask

  task automatic packVector();
    for (int i = 0; i < NENT; i++) begin
      inData[i*W +: W]           = curDist[i];
      inType[i*TYPE_W +: TYPE_W] = curTypes[i];
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents the current vector on the first cycle in_ready is high and
  // holds in_valid for exactly that cycle. Called at posedge+1.
  task automatic applyStimulus(input bit expectResult);
    int waited = 0;
    expect_t e;
    while (in_ready !== 1'b1 && waited < 100) begin
      step(1);
      waited++;
    end
    if (waited >= 100) begin
      failNow("ready_timeout");
      return;
    end
    packVector();
    in_valid = 1'b1;
    lastAcceptInDone = (out_valid === 1'b1);
    if (expectResult) begin
      refVote(e.cls, e.votes);
      e.nearest = int'(curDist[0]);
      e.due     = cyc + LAT;
      sbq.push_back(e);
    end
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      step(1);
      n++;
    end
    if (sbq.size() != 0) begin
      failNow("drain_timeout");
      sbq.delete();
    end
    step(1);
  endtask

  // Monitor: every out_valid pulse must match the oldest outstanding vector.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        failNow("unexpected_out_valid");
      end else begin
        monE = sbq.pop_front();
        checkOutput("out_class",   64'(out_class),   64'(monE.cls));
        checkOutput("out_votes",   64'(out_votes),   64'(monE.votes));
        checkOutput("out_nearest", 64'(out_nearest), 64'(monE.nearest));
        checkOutput("latency",     64'(cyc),         64'(monE.due));
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared + 1, nMismatched + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    inData   = '0;
    inType   = '0;
    step(3);
    checkOutput("rst_in_ready",    64'(in_ready),    64'd1);
    checkOutput("rst_out_valid",   64'(out_valid),   64'd0);
    checkOutput("rst_out_class",   64'(out_class),   64'd0);
    checkOutput("rst_out_votes",   64'(out_votes),   64'd0);
    checkOutput("rst_out_nearest", 64'(out_nearest), 64'd0);
    checkOutput("rst_drop_err",    64'(drop_err),    64'd0);
    rst = 1'b0;
    step(1);

    $display("[TB] majority");
    loadTypes(2, 5, 2, 2, 5, 4);
    applyStimulus(1'b1);
    waitDrain();

    $display("[TB] ties toward nearest");
    loadTypes(6, 1, 1, 6, 3, 4);
    applyStimulus(1'b1);
    waitDrain();
    loadTypes(1, 6, 6, 1, 3, 4);
    applyStimulus(1'b1);
    waitDrain();

    $display("[TB] unanimous max label");
    loadTypes(7, 7, 7, 7, 7, 4);
    curDist[0] = 16'h0042;
    applyStimulus(1'b1);
    waitDrain();

    $display("[TB] busy drop");
    loadTypes(0, 1, 0, 3, 0, 4);
    applyStimulus(1'b1);
    step(2);
    loadTypes(5, 5, 5, 5, 5, 5);
    packVector();
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    checkOutput("drop_err_set", 64'(drop_err), 64'd1);
    waitDrain();
    step(20);
    checkOutput("drop_err_sticky", 64'(drop_err), 64'd1);

    $display("[TB] back-to-back");
    loadTypes(3, 3, 1, 1, 1, 2);
    applyStimulus(1'b1);
    loadTypes(4, 2, 4, 2, 0, 6);
    applyStimulus(1'b1);
    checkOutput("b2b_accept_in_done", 64'(lastAcceptInDone), 64'd1);
    waitDrain();

    $display("[TB] reset mid-count");
    loadTypes(1, 2, 3, 4, 5, 0);
    applyStimulus(1'b0);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checkOutput("midrst_out_valid",   64'(out_valid),   64'd0);
    checkOutput("midrst_out_class",   64'(out_class),   64'd0);
    checkOutput("midrst_out_votes",   64'(out_votes),   64'd0);
    checkOutput("midrst_out_nearest", 64'(out_nearest), 64'd0);
    checkOutput("midrst_in_ready",    64'(in_ready),    64'd1);
    checkOutput("midrst_drop_err",    64'(drop_err),    64'd0);
    step(30);

    $display("[TB] randomized vectors");
    for (int v = 0; v < 40; v++) begin
      int range = $urandom_range(1, NCLASS - 1);
      for (int i = 0; i < NENT; i++) begin
        curTypes[i] = TYPE_W'($urandom_range(0, range));
        curDist[i]  = W'($urandom);
      end
      applyStimulus(1'b1);
      step($urandom_range(0, 18));
    end
    waitDrain();
    step(20);
    checkOutput("final_drop_err", 64'(drop_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
